// File: rtl/ccff_loader_pkg.sv
// rtl/ccff_loader_pkg.sv - shared state encoding and default sizes for the config chain loader.
package ccff_loader_pkg;

  localparam int WORD_W_DEF    = 32;
  localparam int CHAIN_LEN_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_state_e;

endpackage

// File: rtl/ccff_chain_loader_if.sv
// rtl/ccff_chain_loader_if.sv - bitstream word stream into the chain loader.
interface ccff_chain_loader_if
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) ();

  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);

endinterface

// File: rtl/ccff_chain_loader_piso.sv
// rtl/ccff_chain_loader_piso.sv - word-wide parallel-in serial-out register, MSB first.
module ccff_piso
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int RW     = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] load_data,
  input  logic [RW-1:0]     load_bits,
  output logic              msb,
  output logic              empty,
  output logic [RW-1:0]     rem
);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [RW-1:0]     rem_q, rem_d;

  always_comb begin
    sr_d  = sr_q;
    rem_d = rem_q;
    if (load) begin
      sr_d  = load_data;
      rem_d = load_bits;
    end else if (shift && (rem_q != '0)) begin
      sr_d  = sr_q << 1;
      rem_d = rem_q - RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      rem_q <= '0;
    end else begin
      sr_q  <= sr_d;
      rem_q <= rem_d;
    end
  end

  assign msb   = sr_q[WORD_W-1];
  assign empty = (rem_q == '0);
  assign rem   = rem_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serializes bitstream words into the config chain head, with optional tail verify.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                start,
  input  logic                verify,
  ccff_chain_loader_if.slave  word_if,
  output logic                ccff_head,
  input  logic                ccff_tail,
  output logic                chain_shift_en,
  output logic                busy,
  output logic                done,
  output logic                mismatch,
  output logic [CNT_W-1:0]    mismatch_cnt
);

  localparam int RW = $clog2(WORD_W + 1);

  ccff_state_e      state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] mm_cnt_q, mm_cnt_d;

  logic             piso_msb, piso_empty, xfer;
  logic [RW-1:0]    piso_rem, word_bits;
  logic [31:0]      bits_left;

  // The last word of the chain may be partial: only its top bits are loaded as valid.
  assign bits_left = 32'(CHAIN_LEN) - 32'(bit_cnt_q);
  assign word_bits = (bits_left >= 32'(WORD_W)) ? RW'(WORD_W) : RW'(bits_left);

  assign word_if.word_ready = (state_q == FETCH);
  assign xfer               = word_if.word_valid && word_if.word_ready;
  assign chain_shift_en     = (state_q == SHIFT) && !piso_empty;
  assign ccff_head          = chain_shift_en && piso_msb;
  assign busy               = (state_q == FETCH) || (state_q == SHIFT);
  assign done               = (state_q == DONE);
  assign mismatch           = mismatch_q;
  assign mismatch_cnt       = mm_cnt_q;

  ccff_piso #(.WORD_W(WORD_W), .RW(RW)) u_piso (
    .clk       (prog_clk),
    .rst       (pReset),
    .load      (xfer),
    .shift     (chain_shift_en),
    .load_data (word_if.word_data),
    .load_bits (word_bits),
    .msb       (piso_msb),
    .empty     (piso_empty),
    .rem       (piso_rem)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    bit_cnt_d  = bit_cnt_q;
    mismatch_d = mismatch_q;
    mm_cnt_d   = mm_cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = FETCH;
          mode_d    = verify;
          bit_cnt_d = '0;
          if (verify) begin
            mismatch_d = 1'b0;
            mm_cnt_d   = '0;
          end
        end
      end
      FETCH: begin
        if (word_if.word_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (chain_shift_en) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          // The tail emits the bit written at this position during the previous pass.
          if (mode_q && (ccff_tail != piso_msb)) begin
            mismatch_d = 1'b1;
            if (mm_cnt_q != {CNT_W{1'b1}}) mm_cnt_d = mm_cnt_q + CNT_W'(1);
          end
          if (piso_rem == RW'(1)) begin
            state_d = ((32'(bit_cnt_q) + 32'd1) == 32'(CHAIN_LEN)) ? DONE : FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      bit_cnt_q  <= '0;
      mismatch_q <= 1'b0;
      mm_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      bit_cnt_q  <= bit_cnt_d;
      mismatch_q <= mismatch_d;
      mm_cnt_q   <= mm_cnt_d;
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - directed bench for ccff_chain_loader with 16-bit and 12-bit chain models.
module tb_ccff_chain_loader;
  import ccff_loader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, start_s, verify_s, valid_s;
  logic [7:0] data_s;
  int         sel;
  int         checks = 0;
  int         errors = 0;

  ccff_chain_loader_if #(.WORD_W(8)) if_a ();
  ccff_chain_loader_if #(.WORD_W(8)) if_b ();

  logic       start_a, start_b;
  logic       head_a, shift_a, busy_a, done_a, mm_a, tail_a;
  logic       head_b, shift_b, busy_b, done_b, mm_b, tail_b;
  logic [4:0] mmc_a;
  logic [3:0] mmc_b;
  logic [15:0] chain_a = '0;
  logic [11:0] chain_b = '0;

  assign if_a.word_data  = data_s;
  assign if_b.word_data  = data_s;
  assign if_a.word_valid = (sel == 0) && valid_s;
  assign if_b.word_valid = (sel == 1) && valid_s;
  assign start_a         = (sel == 0) && start_s;
  assign start_b         = (sel == 1) && start_s;

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(16)) dut_a (
    .prog_clk       (clk),
    .pReset         (rst_a),
    .start          (start_a),
    .verify         (verify_s),
    .word_if        (if_a),
    .ccff_head      (head_a),
    .ccff_tail      (tail_a),
    .chain_shift_en (shift_a),
    .busy           (busy_a),
    .done           (done_a),
    .mismatch       (mm_a),
    .mismatch_cnt   (mmc_a)
  );

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(12)) dut_b (
    .prog_clk       (clk),
    .pReset         (rst_b),
    .start          (start_b),
    .verify         (verify_s),
    .word_if        (if_b),
    .ccff_head      (head_b),
    .ccff_tail      (tail_b),
    .chain_shift_en (shift_b),
    .busy           (busy_b),
    .done           (done_b),
    .mismatch       (mm_b),
    .mismatch_cnt   (mmc_b)
  );

  // Chain models: advance only when the gate enable is high.
  always @(posedge clk) begin
    if (shift_a) chain_a <= {chain_a[14:0], head_a};
    if (shift_b) chain_b <= {chain_b[10:0], head_b};
  end
  assign tail_a = chain_a[15];
  assign tail_b = chain_b[11];

  logic ready_v, shift_v, head_v, done_v;
  assign ready_v = (sel == 1) ? if_b.word_ready : if_a.word_ready;
  assign shift_v = (sel == 1) ? shift_b : shift_a;
  assign head_v  = (sel == 1) ? head_b  : head_a;
  assign done_v  = (sel == 1) ? done_b  : done_a;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic run_pass(input int s, input logic vfy, input logic [7:0] w0, input logic [7:0] w1,
                          input int gap, input int glitch_cyc, input int rst_shift,
                          output int done_cyc, output logic [31:0] heads, output int nshift,
                          output int nacc, output int gap_shift);
    int   cyc;
    int   gap_cnt;
    logic acc, hold, rdy_seen;
    sel = s; done_cyc = -1; heads = '0; nshift = 0; nacc = 0; gap_shift = 0;
    gap_cnt = 0; hold = 1'b0;
    @(posedge clk); #1 start_s = 1'b1; verify_s = vfy;
    @(posedge clk); #1 start_s = 1'b0; verify_s = 1'b0;
    cyc = 0; valid_s = 1'b1; data_s = w0;
    while (cyc < 200) begin
      @(negedge clk);
      if (done_v) begin
        done_cyc = cyc;
        break;
      end
      if (shift_v) begin
        heads = {heads[30:0], head_v};
        nshift++;
      end
      rdy_seen = ready_v;
      if (hold && rdy_seen && shift_v) gap_shift++;
      acc = valid_s && ready_v;
      if (rst_shift > 0 && nshift == rst_shift) begin
        if (s == 0) rst_a = 1'b1; else rst_b = 1'b1;
        @(posedge clk); #1;
        done_cyc = -2;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      start_s = (glitch_cyc > 0) && (cyc == glitch_cyc);
      if (acc) begin
        nacc++;
        if (nacc == 1) begin
          data_s = w1;
          if (gap > 0) begin
            valid_s = 1'b0;
            hold    = 1'b1;
          end
        end else begin
          data_s = 8'hAA;
        end
      end else if (hold && rdy_seen) begin
        gap_cnt++;
        if (gap_cnt == gap) begin
          valid_s = 1'b1;
          hold    = 1'b0;
        end
      end
    end
    valid_s = 1'b0;
    start_s = 1'b0;
  endtask

  int          dc, ns, na, gs, rcnt;
  logic [31:0] hd;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; start_s = 1'b0; verify_s = 1'b0;
    valid_s = 1'b0; data_s = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, if_a.word_ready}, 32'd0);
    chk("rst_shift", {31'd0, shift_a}, 32'd0);
    chk("rst_head", {31'd0, head_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_mm", {31'd0, mm_a}, 32'd0);
    chk("rst_mmc", {27'd0, mmc_a}, 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;

    run_pass(0, 1'b0, 8'hA5, 8'h3C, 0, 0, 0, dc, hd, ns, na, gs);
    chk("wr_done_cyc", dc, 32'd18);
    chk("wr_shifts", ns, 32'd16);
    chk("wr_heads", hd, 32'h0000A53C);
    chk("wr_words", na, 32'd2);
    chk("wr_chain", {16'd0, chain_a}, 32'h0000A53C);
    chk("wr_busy", {31'd0, busy_a}, 32'd0);

    run_pass(0, 1'b1, 8'hA5, 8'h3C, 0, 0, 0, dc, hd, ns, na, gs);
    chk("vf_done_cyc", dc, 32'd18);
    chk("vf_mm", {31'd0, mm_a}, 32'd0);
    chk("vf_mmc", {27'd0, mmc_a}, 32'd0);

    run_pass(0, 1'b1, 8'hA5, 8'h3D, 0, 0, 0, dc, hd, ns, na, gs);
    chk("vf_bad_mm", {31'd0, mm_a}, 32'd1);
    chk("vf_bad_mmc", {27'd0, mmc_a}, 32'd1);

    run_pass(0, 1'b0, 8'hA5, 8'h3C, 5, 0, 0, dc, hd, ns, na, gs);
    chk("gap_done_cyc", dc, 32'd23);
    chk("gap_shift_en", gs, 32'd0);
    chk("gap_chain", {16'd0, chain_a}, 32'h0000A53C);
    chk("gap_mm_kept", {31'd0, mm_a}, 32'd1);
    chk("gap_mmc_kept", {27'd0, mmc_a}, 32'd1);

    run_pass(0, 1'b0, 8'hA5, 8'h3C, 0, 0, 7, dc, hd, ns, na, gs);
    chk("mid_rst_ret", dc, 32'hFFFFFFFE);
    chk("mid_rst_ready", {31'd0, if_a.word_ready}, 32'd0);
    chk("mid_rst_shift", {31'd0, shift_a}, 32'd0);
    chk("mid_rst_head", {31'd0, head_a}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("mid_rst_done", {31'd0, done_a}, 32'd0);
    chk("mid_rst_mm", {31'd0, mm_a}, 32'd0);
    chk("mid_rst_mmc", {27'd0, mmc_a}, 32'd0);
    rst_a = 1'b0;
    run_pass(0, 1'b0, 8'hA5, 8'h3C, 0, 0, 0, dc, hd, ns, na, gs);
    chk("rerun_done_cyc", dc, 32'd18);
    chk("rerun_chain", {16'd0, chain_a}, 32'h0000A53C);

    run_pass(0, 1'b0, 8'hA5, 8'h3C, 0, 4, 0, dc, hd, ns, na, gs);
    chk("glitch_done_cyc", dc, 32'd18);
    chk("glitch_shifts", ns, 32'd16);
    chk("glitch_heads", hd, 32'h0000A53C);

    @(posedge clk); #1 rst_a = 1'b1; start_s = 1'b1; sel = 0;
    @(posedge clk); #1;
    chk("rst_start_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_start_done", {31'd0, done_a}, 32'd0);
    rst_a = 1'b0; start_s = 1'b0;
    @(posedge clk); #1;
    chk("rst_start_idle", {31'd0, busy_a}, 32'd0);

    run_pass(1, 1'b0, 8'hFF, 8'hF0, 0, 0, 0, dc, hd, ns, na, gs);
    chk("b_done_cyc", dc, 32'd14);
    chk("b_shifts", ns, 32'd12);
    chk("b_heads", hd, 32'h00000FFF);
    chk("b_words", na, 32'd2);
    chk("b_chain", {20'd0, chain_b}, 32'h00000FFF);
    valid_s = 1'b1; data_s = 8'hAA; rcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (if_b.word_ready) rcnt++;
    end
    valid_s = 1'b0;
    chk("b_no_extra_word", rcnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
